// File: rtl/oe_merge_pipe.sv
// rtl/oe_merge_pipe.sv - pipelined bitonic merge of two ascending N-key halves into 2N keys
//
// Purpose:
//   Holds two independently loaded ascending halves A and B. When both are
//   present and the output side can advance, they launch into a chain of
//   STAGES registered compare-exchange stages that produces the merged
//   ascending sequence. B is reversed on entry, which makes the combined
//   vector bitonic.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   load_a     half-A valid, captured when load_a && ready_a
//   load_b     half-B valid, captured when load_b && ready_b
//   ina, inb   N packed keys each, key i at [(i+1)*WIDTH-1 : i*WIDTH]
//   ready_a/b  holding register for that half can accept this cycle
//   c          2N merged keys, smallest at [WIDTH-1:0]
//   out_valid  c holds a complete result
//   out_ready  downstream accepts c when out_valid && out_ready
//   out_err    result came from an unsorted half (only with SORT_CHECK_EN)
//
// Build option:
//   SORT_CHECK_EN  when defined, each half is checked for ascending order at
//                  capture and the flag travels with its result to out_err.
//                  When undefined, out_err is tied to 0.

module oe_merge_pipe #(
  parameter int WIDTH = 3,
  parameter int N     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_a,
  input  logic                   load_b,
  input  logic [N*WIDTH-1:0]     ina,
  input  logic [N*WIDTH-1:0]     inb,
  output logic                   ready_a,
  output logic                   ready_b,
  output logic [2*N*WIDTH-1:0]   c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_err
);

  localparam int STAGES = $clog2(N) + 1;
  localparam int K      = 2 * N;

  logic [N*WIDTH-1:0] hold_a;
  logic [N*WIDTH-1:0] hold_b;
  logic               full_a;
  logic               full_b;
  logic               advance;
  logic               launch;

  logic [K*WIDTH-1:0] v;
  logic [K*WIDTH-1:0] nxt [STAGES];
  logic [K*WIDTH-1:0] sd  [STAGES];
  logic [STAGES-1:0]  sv;

  // One compare-exchange layer at distance d: the lower index of each pair
  // keeps the smaller key. Ties leave the pair untouched.
  function automatic logic [K*WIDTH-1:0] cmpex(input logic [K*WIDTH-1:0] x, input int d);
    logic [K*WIDTH-1:0] y;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    y = x;
    for (int i = 0; i < K; i++) begin
      if ((i % (2 * d)) < d) begin
        lo = x[i*WIDTH +: WIDTH];
        hi = x[(i+d)*WIDTH +: WIDTH];
        if (hi < lo) begin
          y[i*WIDTH +: WIDTH]     = hi;
          y[(i+d)*WIDTH +: WIDTH] = lo;
        end
      end
    end
    return y;
  endfunction

  // A single global enable: every stage shifts together, so bubbles and
  // results stay in lockstep and a stall freezes the whole chain.
  assign advance   = !out_valid || out_ready;
  assign launch    = full_a && full_b && advance;
  assign ready_a   = rst && (!full_a || launch);
  assign ready_b   = rst && (!full_b || launch);
  assign out_valid = sv[STAGES-1];
  assign c         = sd[STAGES-1];

  // Stage-0 input: A ascending followed by B reversed forms a bitonic vector.
  always_comb begin
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i*WIDTH +: WIDTH]     = hold_a[i*WIDTH +: WIDTH];
      v[(N+i)*WIDTH +: WIDTH] = hold_b[(N-1-i)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    nxt[0] = cmpex(v, N);
    for (int s = 1; s < STAGES; s++) begin
      nxt[s] = cmpex(sd[s-1], N >> s);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
      sv     <= '0;
      for (int s = 0; s < STAGES; s++) begin
        sd[s] <= '0;
      end
    end else begin
      // A reload in the launch cycle keeps the flag set for the new half.
      if (load_a && ready_a) begin
        hold_a <= ina;
        full_a <= 1'b1;
      end else if (launch) begin
        full_a <= 1'b0;
      end
      if (load_b && ready_b) begin
        hold_b <= inb;
        full_b <= 1'b1;
      end else if (launch) begin
        full_b <= 1'b0;
      end
      if (advance) begin
        sv <= {sv[STAGES-2:0], launch};
        for (int s = 0; s < STAGES; s++) begin
          sd[s] <= nxt[s];
        end
      end
    end
  end

`ifdef SORT_CHECK_EN
  logic              err_a;
  logic              err_b;
  logic [STAGES-1:0] se;

  function automatic logic is_unsorted(input logic [N*WIDTH-1:0] h);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (h[i*WIDTH +: WIDTH] > h[(i+1)*WIDTH +: WIDTH]) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_a <= 1'b0;
      err_b <= 1'b0;
      se    <= '0;
    end else begin
      if (load_a && ready_a) begin
        err_a <= is_unsorted(ina);
      end
      if (load_b && ready_b) begin
        err_b <= is_unsorted(inb);
      end
      if (advance) begin
        se <= {se[STAGES-2:0], launch && (err_a || err_b)};
      end
    end
  end

  assign out_err = se[STAGES-1];
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_oe_merge_pipe.sv
// tb/tb_oe_merge_pipe.sv - scoreboard bench for oe_merge_pipe with a sort-based reference model

module tb_oe_merge_pipe;

  localparam int WIDTH  = 3;
  localparam int N      = 8;
  localparam int K      = 2 * N;
  localparam int STAGES = $clog2(N) + 1;

  typedef logic [N*WIDTH-1:0] half_t;
  typedef logic [K*WIDTH-1:0] vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  load_a = 1'b0;
  logic  load_b = 1'b0;
  logic  out_ready = 1'b1;
  half_t ina = '0;
  half_t inb = '0;
  logic  ready_a;
  logic  ready_b;
  logic  out_valid;
  logic  out_err;
  vec_t  c;

  always #5 clk = ~clk;

  oe_merge_pipe #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .load_a(load_a), .load_b(load_b),
    .ina(ina), .inb(inb), .ready_a(ready_a), .ready_b(ready_b),
    .c(c), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int stalls = 0;

  vec_t exp_q[$];
  int   lat_q[$];
  int   stall_q[$];
  bit   err_q[$];

  bit    mfa = 0;
  bit    mfb = 0;
  half_t ha = '0;
  half_t hb = '0;
  bit    hold_c_valid = 0;
  vec_t  held_c = '0;
  bit    rst_seen = 0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: the merged output is just the 2N keys in ascending order.
  function automatic vec_t sort_vec(input vec_t x);
    int   q[$];
    vec_t y;
    for (int i = 0; i < K; i++) q.push_back(int'(x[i*WIDTH +: WIDTH]));
    q.sort();
    y = '0;
    for (int i = 0; i < K; i++) y[i*WIDTH +: WIDTH] = WIDTH'(q[i]);
    return y;
  endfunction

  function automatic bit half_unsorted(input half_t h);
    bit bad = 0;
    for (int i = 0; i < N - 1; i++)
      if (h[i*WIDTH +: WIDTH] > h[(i+1)*WIDTH +: WIDTH]) bad = 1;
    return bad;
  endfunction

  function automatic half_t pack(input int k[N]);
    half_t h = '0;
    for (int i = 0; i < N; i++) h[i*WIDTH +: WIDTH] = WIDTH'(k[i]);
    return h;
  endfunction

  function automatic half_t rand_half();
    int    q[$];
    half_t h = '0;
    for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(0, (1 << WIDTH) - 1)));
    q.sort();
    for (int i = 0; i < N; i++) h[i*WIDTH +: WIDTH] = WIDTH'(q[i]);
    return h;
  endfunction

  // Monitor: samples at negedge, predicts handshakes, scores every accepted result.
  always @(negedge clk) begin
    bit   adv;
    bit   lau;
    bit   er;
    vec_t e;
    int   l;
    int   s;
    cycle++;
    if (rst_seen && rst) begin
      check("reset_out_valid", vec_t'(out_valid), '0);
      check("reset_c", c, '0);
      check("reset_out_err", vec_t'(out_err), '0);
    end
    rst_seen = 0;
    if (!rst) begin
      check("reset_ready_a", vec_t'(ready_a), '0);
      check("reset_ready_b", vec_t'(ready_b), '0);
      exp_q.delete(); lat_q.delete(); stall_q.delete(); err_q.delete();
      mfa = 0; mfb = 0; hold_c_valid = 0; rst_seen = 1;
    end else begin
      if (hold_c_valid) begin
        check("stall_c_hold", c, held_c);
        check("stall_valid_hold", vec_t'(out_valid), vec_t'(1));
      end
      adv = !out_valid || out_ready;
      lau = mfa && mfb && adv;
      check("ready_a", vec_t'(ready_a), vec_t'(!mfa || lau));
      check("ready_b", vec_t'(ready_b), vec_t'(!mfb || lau));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got c=%h with no result outstanding (cycle %0d)", c, cycle);
        end else begin
          e = exp_q.pop_front(); l = lat_q.pop_front();
          s = stall_q.pop_front(); er = err_q.pop_front();
          if (er) check("c_permutation", sort_vec(c), e);
          else    check("c", c, e);
          check("out_err", vec_t'(out_err), vec_t'(er));
          if (s == stalls) check("latency", vec_t'(cycle - l), vec_t'(STAGES));
        end
      end
      if (!adv) stalls++;
      hold_c_valid = out_valid && !out_ready;
      held_c = c;
      if (lau) begin
        exp_q.push_back(sort_vec({hb, ha}));
        lat_q.push_back(cycle);
        stall_q.push_back(stalls);
`ifdef SORT_CHECK_EN
        err_q.push_back(half_unsorted(ha) || half_unsorted(hb));
`else
        err_q.push_back(1'b0);
`endif
      end
      if (load_a && (!mfa || lau)) begin ha = ina; mfa = 1; end
      else if (lau) mfa = 0;
      if (load_b && (!mfb || lau)) begin hb = inb; mfb = 1; end
      else if (lau) mfb = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k_up[N]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int k_odd[N] = '{1, 1, 3, 3, 5, 5, 7, 7};
    int k_evn[N] = '{0, 0, 2, 2, 4, 4, 6, 6};
    int k_two[N] = '{2, 2, 2, 2, 2, 2, 2, 2};
    int k_bad[N] = '{3, 1, 0, 0, 0, 0, 0, 0};

    rst = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // Identical ascending halves, A then B.
    load_a = 1; ina = pack(k_up); cyc();
    load_a = 0; load_b = 1; inb = pack(k_up); cyc();
    load_b = 0;
    repeat (8) cyc();

    // B first; a second B while held must be ignored; A three cycles later.
    load_b = 1; inb = pack(k_odd); cyc();
    load_b = 0; cyc();
    load_b = 1; inb = pack(k_two); cyc();
    load_b = 0; load_a = 1; ina = pack(k_evn); cyc();
    load_a = 0;
    repeat (8) cyc();

    // Back-to-back full throughput.
    for (int i = 0; i < 5; i++) begin
      load_a = 1; load_b = 1; ina = rand_half(); inb = rand_half(); cyc();
    end
    load_a = 0; load_b = 0;
    repeat (8) cyc();

    // Backpressure while loads continue.
    for (int i = 0; i < 12; i++) begin
      out_ready = !(i >= 3 && i < 9);
      load_a = 1; load_b = 1; ina = rand_half(); inb = rand_half(); cyc();
    end
    load_a = 0; load_b = 0; out_ready = 1;
    repeat (12) cyc();

    // Reset with results in flight.
    for (int i = 0; i < 3; i++) begin
      load_a = 1; load_b = 1; ina = rand_half(); inb = rand_half(); cyc();
    end
    load_a = 0; load_b = 0; rst = 0; cyc();
    rst = 1;
    repeat (10) cyc();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      load_a = 1'($urandom_range(0, 1)); load_b = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      ina = rand_half(); inb = rand_half(); cyc();
    end
    load_a = 0; load_b = 0; out_ready = 1;
    repeat (12) cyc();

`ifdef SORT_CHECK_EN
    load_a = 1; load_b = 1; ina = pack(k_bad); inb = pack(k_up); cyc();
    ina = pack(k_up); inb = pack(k_odd); cyc();
    load_a = 0; load_b = 0;
    repeat (10) cyc();
`else
    ina = pack(k_bad);
`endif

    repeat (4) cyc();
    check("results_drained", vec_t'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oe_merge_pipe.md
Name: oe_merge_pipe

Overview:
- Pipelined, parametrised merge engine for the V2V sorter.
- Accepts two independently loaded, ascending-sorted sequences A and B of N keys each, and emits the merged ascending sequence of 2N keys.
- One merge result per clock at full throughput, with an output-side valid/ready stall.
- Successor to the combinational fixed-size merge: arbitrary power-of-two N, registered comparator stages, per-half load handshake, backpressure.

Parameters:
WIDTH, 3, key width in bits.
N, 8, keys per input half; power of two, N >= 2; output holds 2N keys.
STAGES, log2(N)+1 (derived localparam, not overridable), number of registered comparator stages.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous reset, active-low; sampled on rising clk.
load_a  in  1  half-A valid; A captured when load_a && ready_a.
load_b  in  1  half-B valid; B captured when load_b && ready_b.
ina  in  N*WIDTH  half A, key i at [(i+1)*WIDTH-1 : i*WIDTH], ascending with i.
inb  in  N*WIDTH  half B, same packing, ascending.
ready_a  out  1  A holding register can accept this cycle.
ready_b  out  1  B holding register can accept this cycle.
c  out  2*N*WIDTH  merged keys; key 0 = smallest, at [WIDTH-1:0].
out_valid  out  1  c holds a complete result.
out_ready  in  1  downstream accepts c when out_valid && out_ready.
out_err  out  1  result came from an unsorted input half (see Optional Feature).

Behaviour:
- Reset (rst==0 at an edge): full_a, full_b, all stage valid bits, c, out_valid and out_err go to 0. ready_a and ready_b are forced 0 while rst==0. Reset mid-operation discards any captured halves and in-flight results, with no partial output.
- advance = !out_valid || out_ready. This single global enable shifts every pipeline stage.
- launch = full_a && full_b && advance.
- ready_a = rst && (!full_a || launch). ready_b is the same with full_b.
- A half may be loaded in the same cycle that the previously held half launches.
- Capture: on load_a && ready_a, hold_a <= ina and full_a <= 1. The flag clears on launch unless it is reloaded in the same cycle. B behaves the same way.
- A and B may arrive in any order and on any cycles. The second load while full and not launching is ignored; ready is 0 in that case.
- Stage 0 input vector: v[i] = hold_a[i] for i < N; v[N+i] = hold_b[N-1-i]. B is reversed, so v is bitonic.
- Stage s (s = 0..STAGES-1) uses distance d = N >> s.
  - For each index i with (i mod 2d) < d, compare v[i] with v[i+d]: the smaller goes to i, the larger to i+d.
  - On equal keys, i takes v[i]; the result is identical either way.
  - Unsigned comparison.
  - Each stage output is registered together with a valid bit, shifted only when advance=1.
- Latency: a result launched at edge t appears with out_valid=1 after edge t+STAGES. For N=8, the result is visible 4 cycles after the launch edge.
- Throughput: one result per cycle when out_ready=1 and loads keep both halves full.
- Stall: with out_valid && !out_ready, c and all stages hold, and no launch occurs. Holding registers still accept a load into an empty half.
- Bubbles: an invalid stage entry (valid=0) propagates as a bubble. Its data registers may hold stale values but are never presented with out_valid=1.
- Inputs are not checked for sortedness unless SORT_CHECK_EN is defined. Unsorted input gives an unspecified permutation of the 2N keys, never lost or duplicated keys.

Optional Feature:
SORT_CHECK_EN
- Defined:
  - At capture, a sortedness check on each half sets err_a/err_b if any key[i] > key[i+1].
  - On launch, err_a|err_b travels down the pipeline beside the stage valid bits, and appears on out_err with its result.
  - out_err is valid only while out_valid=1 and is cleared by reset.
- Not defined: out_err is tied to 0 and no check logic is built.

Test Plan:
- N=8, WIDTH=3. Load A={0,1,2,3,4,5,6,7} then B={0,1,2,3,4,5,6,7} the next cycle, out_ready=1 -> c={0,0,1,1,...,7,7}, out_valid high 4 cycles after launch, for exactly 1 cycle.
- Load B={1,1,3,3,5,5,7,7} first, then A={0,0,2,2,4,4,6,6} 3 cycles later -> c={0,0,1,1,2,2,...,7,7}. ready_b=0 between the two loads; a second load_b in that window is ignored.
- Back-to-back: assert load_a and load_b every cycle for 5 results with out_ready=1 -> 5 consecutive out_valid cycles, each correct, ready_a/ready_b held at 1.
- Backpressure: out_ready=0 for 6 cycles while results are in flight -> c stable, at most STAGES results plus 2 held halves buffered. After release, results drain in order with none lost.
- Reset mid-flight: rst=0 for 1 cycle with 3 results in the pipe -> out_valid=0, c=0, ready_a=ready_b=0 during reset, then 1. No stale result emerges afterwards.
- SORT_CHECK_EN defined: A={3,1,0,0,0,0,0,0}, B sorted -> out_err=1 with that result. The following all-sorted result has out_err=0.
